// File: rtl/mem_if_pkg.sv
// Shared types and default channel widths for the minimal-memory interface blocks.
package mem_if_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arbState_t;

   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_SIZE_W = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first pending index after the last winner.
module rr_priority_pick #(
   parameter int N_REQ   = 2,
   parameter int GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0]   i_pending,
   input  logic [GRANT_W-1:0] i_lastGrant,
   output logic [GRANT_W-1:0] o_index,
   output logic               o_valid
);

   // Scan from farthest to nearest so the nearest pending index is written last and wins.
   always_comb begin
      o_index = '0;
      o_valid = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (i_pending[(int'(i_lastGrant) + k) % N_REQ]) begin
            o_index = GRANT_W'((int'(i_lastGrant) + k) % N_REQ);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one minimal-memory channel among N_REQ masters,
// holding each grant until the memory answers, the master withdraws, or the watchdog fires.
module mem_port_arbiter
   import mem_if_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SIZE_W  = DEF_SIZE_W,
   parameter int TIMEOUT = 64,
   parameter int GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          R_oe_ram,
   input  logic [N_REQ-1:0]          R_we_ram,
   input  logic [N_REQ*ADDR_W-1:0]   R_addr_ram,
   input  logic [N_REQ*DATA_W-1:0]   R_Wdata_ram,
   input  logic [N_REQ*SIZE_W-1:0]   R_data_ram_size,
   output logic [N_REQ*DATA_W-1:0]   R_Rdata_ram,
   output logic [N_REQ-1:0]          R_DataRdy,
   output logic                      Mout_oe_ram,
   output logic                      Mout_we_ram,
   output logic [ADDR_W-1:0]         Mout_addr_ram,
   output logic [DATA_W-1:0]         Mout_Wdata_ram,
   output logic [SIZE_W-1:0]         Mout_data_ram_size,
   input  logic [DATA_W-1:0]         M_Rdata_ram,
   input  logic                      M_DataRdy,
   output logic [GRANT_W-1:0]        grant,
   output logic                      busy,
   output logic                      err
);

   localparam int                  WDOG_W    = $clog2(TIMEOUT);
   localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(TIMEOUT - 1);
   localparam logic [GRANT_W-1:0]  LAST_INIT = GRANT_W'(N_REQ - 1);

   arbState_t            r_state;
   logic [GRANT_W-1:0]   r_grant;
   logic [GRANT_W-1:0]   r_lastGrant;
   logic [WDOG_W-1:0]    r_wdog;
   logic                 r_err;

   arbState_t            w_nextState;
   logic [GRANT_W-1:0]   w_nextGrant;
   logic [GRANT_W-1:0]   w_nextLastGrant;
   logic [WDOG_W-1:0]    w_nextWdog;
   logic                 w_nextErr;

   logic [N_REQ-1:0]     w_pending;
   logic [N_REQ-1:0]     w_illegal;
   logic [GRANT_W-1:0]   w_pickIndex;
   logic                 w_pickValid;
   logic                 w_selOe;
   logic                 w_selWe;
   logic [ADDR_W-1:0]    w_selAddr;
   logic [DATA_W-1:0]    w_selWdata;
   logic [SIZE_W-1:0]    w_selSize;
   logic                 w_active;
   logic                 w_grantPending;
   logic                 w_forward;
   logic                 w_done;

   // A master asserting both oe and we is illegal; the xor drops it from arbitration.
   assign w_pending = R_oe_ram ^ R_we_ram;
   assign w_illegal = R_oe_ram & R_we_ram;

   rr_priority_pick #(
      .N_REQ   (N_REQ),
      .GRANT_W (GRANT_W)
   ) u_pick (
      .i_pending   (w_pending),
      .i_lastGrant (r_lastGrant),
      .o_index     (w_pickIndex),
      .o_valid     (w_pickValid)
   );

   assign w_selOe    = R_oe_ram[r_grant];
   assign w_selWe    = R_we_ram[r_grant];
   assign w_selAddr  = R_addr_ram[int'(r_grant)*ADDR_W +: ADDR_W];
   assign w_selWdata = R_Wdata_ram[int'(r_grant)*DATA_W +: DATA_W];
   assign w_selSize  = R_data_ram_size[int'(r_grant)*SIZE_W +: SIZE_W];

   // Gating with reset keeps the channel quiet in the very cycle reset is asserted.
   assign w_active       = (r_state == BUSY) && reset;
   assign w_grantPending = w_pending[r_grant];
   assign w_forward      = w_active && w_grantPending;
   assign w_done         = w_forward && M_DataRdy;

   assign Mout_oe_ram        = w_forward && w_selOe;
   assign Mout_we_ram        = w_forward && w_selWe;
   assign Mout_addr_ram      = w_active ? w_selAddr  : '0;
   assign Mout_Wdata_ram     = w_active ? w_selWdata : '0;
   assign Mout_data_ram_size = w_active ? w_selSize  : '0;

   always_comb begin
      R_DataRdy   = '0;
      R_Rdata_ram = '0;
      if (w_done) begin
         R_DataRdy[r_grant] = 1'b1;
         if (w_selOe) begin
            R_Rdata_ram[int'(r_grant)*DATA_W +: DATA_W] = M_Rdata_ram;
         end
      end
   end

   always_comb begin
      w_nextState     = r_state;
      w_nextGrant     = r_grant;
      w_nextLastGrant = r_lastGrant;
      w_nextWdog      = r_wdog;
      w_nextErr       = r_err | (|w_illegal);
      case (r_state)
         IDLE: begin
            w_nextWdog = '0;
            if (w_pickValid) begin
               w_nextGrant = w_pickIndex;
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            w_nextWdog = r_wdog + 1'b1;
            // Completion, withdrawal and timeout all release the channel and demote this master.
            if (!w_grantPending || M_DataRdy || (r_wdog == WDOG_LAST)) begin
               w_nextState     = IDLE;
               w_nextLastGrant = r_grant;
               w_nextWdog      = '0;
               if (w_grantPending && !M_DataRdy) begin
                  w_nextErr = 1'b1;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_lastGrant <= LAST_INIT;
         r_wdog      <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_grant     <= w_nextGrant;
         r_lastGrant <= w_nextLastGrant;
         r_wdog      <= w_nextWdog;
         r_err       <= w_nextErr;
      end
   end

   assign grant = r_grant;
   assign busy  = (r_state == BUSY);
   assign err   = r_err;

endmodule
